// File: rtl/seg7_scan_driver_if.sv
// Bus between the CPU datapath and the 4-digit 7-segment scan driver.
// The datapath (master) supplies value, decimal points and controls; the
// driver (slave) owns the board-level anode/cathode pins and the frame pulse.
interface seg7_scan_driver_if;
   logic [15:0] value;
   logic        load;
   logic [3:0]  dp;
   logic        blank;
   logic [3:0]  an;
   logic [7:0]  cat;
   logic        frame;

   modport master (
      output value, load, dp, blank,
      input  an, cat, frame
   );

   modport slave (
      input  value, load, dp, blank,
      output an, cat, frame
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Shows a 16-bit value as four hex digits, one digit per PRESCALE-cycle slot,
// with DEAD dark cycles at the start of each slot to suppress ghosting.
// Outputs are registered: everything seen on an/cat/frame reflects the
// counter, digit index, shadow registers and blank from the previous cycle.
module seg7_scan_driver #(
   parameter int PRESCALE = 1000,
   parameter int DEAD     = 1,
   parameter int BLANK_LZ = 1
) (
   input  logic                clk,
   input  logic                rst,
   seg7_scan_driver_if.slave   bus
);

   localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);
   localparam logic [15:0] CNT_DEAD = 16'(DEAD);

   logic [15:0] cnt;
   logic [1:0]  idx;
   logic [15:0] sh_value;
   logic [3:0]  sh_dp;

   logic [3:0]  an_p0;
   logic [7:0]  cat_p0;
   logic        frame_p0;
   logic        slot_end_p0;
   logic        dig_en_p0;
   logic [3:0]  nibble_p0;

   logic [3:0]  an_p1;
   logic [7:0]  cat_p1;
   logic        frame_p1;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
   function automatic logic [6:0] seg_code(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Index of the most significant nonzero nibble; 0 for a zero value so a
   // lone "0" is still shown.
   function automatic logic [1:0] top_digit(input logic [15:0] v);
      logic [1:0] h;
      if (v[15:12] != 4'h0)     h = 2'd3;
      else if (v[11:8] != 4'h0) h = 2'd2;
      else if (v[7:4] != 4'h0)  h = 2'd1;
      else                      h = 2'd0;
      return h;
   endfunction

   // Shadow registers: a load only replaces what is shown, never the scan phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_value <= 16'h0000;
         sh_dp    <= 4'h0;
      end else if (bus.load) begin
         sh_value <= bus.value;
         sh_dp    <= bus.dp;
      end
   end

   // Slot prescaler and digit index; idx advances once per PRESCALE cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 16'h0000;
         idx <= 2'd0;
      end else if (slot_end_p0) begin
         cnt <= 16'h0000;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 16'h0001;
      end
   end

   // Stage p0: decode the current slot into the next pin values.
   always_comb begin
      slot_end_p0 = (cnt == CNT_LAST);
      nibble_p0   = sh_value[{idx, 2'b00} +: 4];
      dig_en_p0   = !bus.blank && !((BLANK_LZ != 0) && (idx > top_digit(sh_value)));
      an_p0       = 4'hF;
      cat_p0      = 8'hFF;
      if (dig_en_p0 && (cnt >= CNT_DEAD)) begin
         an_p0  = ~(4'b0001 << idx);
         cat_p0 = {~sh_dp[idx], seg_code(nibble_p0)};
      end
      frame_p0    = slot_end_p0 && (idx == 2'd3);
   end

   // Stage p1: registered pins; reset forces the display dark immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_p1    <= 4'hF;
         cat_p1   <= 8'hFF;
         frame_p1 <= 1'b0;
      end else begin
         an_p1    <= an_p0;
         cat_p1   <= cat_p0;
         frame_p1 <= frame_p0;
      end
   end

   assign bus.an    = an_p1;
   assign bus.cat   = cat_p1;
   assign bus.frame = frame_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with PRESCALE=4, DEAD=1, BLANK_LZ=1.
// k counts clock edges since reset release; after edge k the pins show slot
// ((k-1)/4)%4 at phase (k-1)%4, phase 0 being the dark dead-time cycle.
module tb_seg7_scan_driver;
   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   k;

   seg7_scan_driver_if bus ();

   seg7_scan_driver #(.PRESCALE(4), .DEAD(1), .BLANK_LZ(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      k = k + 1;
   endtask

   // Expected {an, cat} after edge kk for per-digit codes and enable mask.
   function automatic logic [11:0] expect_out(input int kk, input logic [31:0] cats,
                                              input logic [3:0] en);
      int p;
      int d;
      logic [3:0] a;
      logic [7:0] c;
      p = (kk - 1) % 4;
      d = ((kk - 1) / 4) % 4;
      if (p == 0 || !en[d]) begin
         a = 4'hF;
         c = 8'hFF;
      end else begin
         a = ~(4'b0001 << d);
         c = cats[d*8 +: 8];
      end
      return {a, c};
   endfunction

   task automatic load_value(input logic [15:0] v, input logic [3:0] d);
      bus.value = v;
      bus.dp    = d;
      bus.load  = 1'b1;
      step();
      bus.load  = 1'b0;
      while (k % 16 != 0) step();
   endtask

   task automatic test_reset();
      logic [11:0] e;
      rst = 1'b1;
      #12;
      total++;
      if (bus.an !== 4'hF || bus.cat !== 8'hFF || bus.frame !== 1'b0) begin
         bad++;
         $display("FAIL reset_init an=%h cat=%h frame=%b want F/FF/0", bus.an, bus.cat, bus.frame);
      end
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      load_value(16'h12AF, 4'h0);
      // mid-scan: digit 0 lit at k=18
      step();
      step();
      total++;
      if (bus.an !== 4'hE || bus.cat !== 8'h8E) begin
         bad++;
         $display("FAIL reset_prelit an=%h cat=%h want E/8E", bus.an, bus.cat);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (bus.an !== 4'hF || bus.cat !== 8'hFF || bus.frame !== 1'b0) begin
         bad++;
         $display("FAIL reset_async an=%h cat=%h frame=%b want F/FF/0", bus.an, bus.cat, bus.frame);
      end
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      // shadow cleared: value 0 shows a single "0" on digit 0
      for (int j = 0; j < 16; j++) begin
         step();
         e = expect_out(k, 32'hFFFFFFC0, 4'b0001);
         total++;
         if (bus.an !== e[11:8] || bus.cat !== e[7:0] || bus.frame !== (k % 16 == 0)) begin
            bad++;
            $display("FAIL reset_restart k=%0d an=%h cat=%h frame=%b want %h/%h/%b",
                     k, bus.an, bus.cat, bus.frame, e[11:8], e[7:0], (k % 16 == 0));
         end
      end
   endtask

   task automatic test_display(input string name, input logic [15:0] v, input logic [3:0] d,
                               input logic [31:0] cats, input logic [3:0] en);
      logic [11:0] e;
      load_value(v, d);
      for (int j = 0; j < 32; j++) begin
         step();
         e = expect_out(k, cats, en);
         total++;
         if (bus.an !== e[11:8] || bus.cat !== e[7:0]) begin
            bad++;
            $display("FAIL %s k=%0d an=%h cat=%h want %h/%h", name, k, bus.an, bus.cat, e[11:8], e[7:0]);
         end
         total++;
         if (bus.frame !== (k % 16 == 0)) begin
            bad++;
            $display("FAIL %s_frame k=%0d frame=%b want %b", name, k, bus.frame, (k % 16 == 0));
         end
      end
   endtask

   task automatic test_blank();
      logic [11:0] e;
      load_value(16'h12AF, 4'h0);
      bus.blank = 1'b1;
      for (int j = 0; j < 10; j++) begin
         step();
         total++;
         if (bus.an !== 4'hF || bus.cat !== 8'hFF) begin
            bad++;
            $display("FAIL blank k=%0d an=%h cat=%h want F/FF", k, bus.an, bus.cat);
         end
      end
      bus.blank = 1'b0;
      for (int j = 0; j < 22; j++) begin
         step();
         e = expect_out(k, 32'hF9A4888E, 4'hF);
         total++;
         if (bus.an !== e[11:8] || bus.cat !== e[7:0] || bus.frame !== (k % 16 == 0)) begin
            bad++;
            $display("FAIL blank_resume k=%0d an=%h cat=%h frame=%b want %h/%h/%b",
                     k, bus.an, bus.cat, bus.frame, e[11:8], e[7:0], (k % 16 == 0));
         end
      end
   endtask

   task automatic test_load_midslot();
      logic [11:0] e;
      load_value(16'h1111, 4'h0);
      step();
      step();
      total++;
      if (bus.an !== 4'hE || bus.cat !== 8'hF9) begin
         bad++;
         $display("FAIL load_before an=%h cat=%h want E/F9", bus.an, bus.cat);
      end
      bus.value = 16'h2222;
      bus.load  = 1'b1;
      step();
      bus.load  = 1'b0;
      total++;
      if (bus.an !== 4'hE || bus.cat !== 8'hF9) begin
         bad++;
         $display("FAIL load_edge an=%h cat=%h want E/F9", bus.an, bus.cat);
      end
      step();
      total++;
      if (bus.an !== 4'hE || bus.cat !== 8'hA4) begin
         bad++;
         $display("FAIL load_next an=%h cat=%h want E/A4", bus.an, bus.cat);
      end
      for (int j = 0; j < 16; j++) begin
         step();
         e = expect_out(k, 32'hA4A4A4A4, 4'hF);
         total++;
         if (bus.an !== e[11:8] || bus.cat !== e[7:0] || bus.frame !== (k % 16 == 0)) begin
            bad++;
            $display("FAIL load_phase k=%0d an=%h cat=%h frame=%b want %h/%h/%b",
                     k, bus.an, bus.cat, bus.frame, e[11:8], e[7:0], (k % 16 == 0));
         end
      end
   endtask

   task automatic test_random();
      int lit;
      for (int j = 0; j < 4000; j++) begin
         bus.value = 16'($urandom);
         bus.dp    = 4'($urandom);
         bus.load  = ($urandom_range(0, 7) == 0);
         bus.blank = ($urandom_range(0, 15) == 0);
         step();
         lit = 0;
         for (int b = 0; b < 4; b++) if (!bus.an[b]) lit++;
         total++;
         if (lit > 1) begin
            bad++;
            $display("FAIL rand_onehot k=%0d an=%h", k, bus.an);
         end
         total++;
         if (bus.frame !== (k % 16 == 0)) begin
            bad++;
            $display("FAIL rand_frame k=%0d frame=%b want %b", k, bus.frame, (k % 16 == 0));
         end
      end
      bus.load  = 1'b0;
      bus.blank = 1'b0;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      k         = 0;
      rst       = 1'b1;
      bus.value = 16'h0000;
      bus.dp    = 4'h0;
      bus.load  = 1'b0;
      bus.blank = 1'b0;
      test_reset();
      test_display("disp_12AF", 16'h12AF, 4'h0, 32'hF9A4888E, 4'hF);
      test_display("lz_0035",   16'h0035, 4'h0, 32'hFFFFB092, 4'b0011);
      test_display("lz_0000",   16'h0000, 4'h0, 32'hFFFFFFC0, 4'b0001);
      test_display("lz_0100",   16'h0100, 4'h0, 32'hFFF9C0C0, 4'b0111);
      test_display("dp_8888",   16'h8888, 4'b0100, 32'h80008080, 4'hF);
      test_blank();
      test_load_midslot();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule
